pg_port_controller: RTL and testbench

// Per-input-port power-gating controller for a router. Counts flit arrivals per

---
 rtl/pg_port_controller_if.sv | 28 ++
 rtl/pg_port_controller.sv | 103 ++++++++++
 tb/tb_pg_port_controller.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pg_port_controller_if.sv
// Handshake and status bundle between a router input port and its
// power-gating controller.
interface pg_port_controller_if #(
  parameter int CNT_W = 7
);
  logic             pgEnable;
  logic             flitValid;
  logic             bufEmpty;
  logic             wakeReq;
  logic             pgSleep;
  logic             portReady;
  logic             wakeAck;
  logic [1:0]       pgState;
  logic [CNT_W-1:0] utilCount;
  logic             pgError;

  // Router / epoch-counter side: drives demand and epoch, observes gating.
  modport master (
    output pgEnable, flitValid, bufEmpty, wakeReq,
    input  pgSleep, portReady, wakeAck, pgState, utilCount, pgError
  );

  // Controller side.
  modport slave (
    input  pgEnable, flitValid, bufEmpty, wakeReq,
    output pgSleep, portReady, wakeAck, pgState, utilCount, pgError
  );
endinterface

// File: rtl/pg_port_controller.sv
// Per-input-port power-gating controller. Counts flits per epoch, gates the
// port buffer after an underused epoch (via a drain phase), and brings it
// back through a fixed-length wake-up phase on demand or on a stray flit.
module pg_port_controller #(
  parameter int CNT_W       = 7,
  parameter int IDLE_THRESH = 4,
  parameter int WAKE_LAT    = 8
) (
  input logic clk,
  input logic reset,
  pg_port_controller_if.slave pgIf
);

  typedef enum logic [1:0] {
    ACTIVE = 2'b00,
    DRAIN  = 2'b01,
    SLEEP  = 2'b10,
    WAKE   = 2'b11
  } pgStateT;

  localparam logic [7:0] WAKE_LOAD = 8'(WAKE_LAT - 1);

  pgStateT          state;
  pgStateT          nextState;
  logic [7:0]       wakeCnt;
  logic [7:0]       nextWakeCnt;
  logic [CNT_W-1:0] utilCount;
  logic [CNT_W:0]   epochSum;
  logic [CNT_W-1:0] epochTot;
  logic             wakeAck;
  logic             pgError;
  logic             wakeDone;

  // Running epoch total including this cycle's flit, saturating at all-ones
  // so a busy epoch can never wrap around and look idle.
  always_comb begin
    epochSum = {1'b0, utilCount} + (CNT_W + 1)'(pgIf.flitValid);
    epochTot = epochSum[CNT_W] ? {CNT_W{1'b1}} : epochSum[CNT_W-1:0];
  end

  assign wakeDone = (state == WAKE) && (wakeCnt == 8'd0);

  // Next-state and wake-counter logic; the counter only moves in WAKE so
  // late demand cannot stretch or restart an ongoing wake-up.
  always_comb begin
    nextState   = state;
    nextWakeCnt = wakeCnt;
    case (state)
      ACTIVE: begin
        if (pgIf.pgEnable && (epochTot < CNT_W'(IDLE_THRESH)) && !pgIf.wakeReq)
          nextState = DRAIN;
      end
      DRAIN: begin
        if (pgIf.wakeReq)
          nextState = ACTIVE;
        else if (pgIf.bufEmpty && !pgIf.flitValid)
          nextState = SLEEP;
      end
      SLEEP: begin
        if (pgIf.wakeReq || pgIf.flitValid) begin
          nextState   = WAKE;
          nextWakeCnt = WAKE_LOAD;
        end
      end
      WAKE: begin
        if (wakeCnt == 8'd0)
          nextState = ACTIVE;
        else
          nextWakeCnt = wakeCnt - 8'd1;
      end
      default: nextState = ACTIVE;
    endcase
  end

  // State, wake counter, epoch counter and the registered status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ACTIVE;
      wakeCnt   <= 8'd0;
      utilCount <= '0;
      wakeAck   <= 1'b0;
      pgError   <= 1'b0;
    end else begin
      state     <= nextState;
      wakeCnt   <= nextWakeCnt;
      utilCount <= pgIf.pgEnable ? '0 : epochTot;
      wakeAck   <= wakeDone;
      if ((state == SLEEP) && pgIf.flitValid)
        pgError <= 1'b1;
    end
  end

  // Power switch and upstream ready are pure decodes of the state register.
  always_comb begin
    pgIf.portReady = (state == ACTIVE);
    pgIf.pgSleep   = (state == SLEEP);
    pgIf.pgState   = state;
    pgIf.utilCount = utilCount;
    pgIf.wakeAck   = wakeAck;
    pgIf.pgError   = pgError;
  end

endmodule

// File: tb/tb_pg_port_controller.sv
// Self-checking bench for pg_port_controller: expected output vectors are
// queued as stimulus is applied and compared once the DUT has clocked.
module tb_pg_port_controller;

  localparam logic [1:0] S_ACTIVE = 2'b00;
  localparam logic [1:0] S_DRAIN  = 2'b01;
  localparam logic [1:0] S_SLEEP  = 2'b10;
  localparam logic [1:0] S_WAKE   = 2'b11;

  typedef struct {
    string       name;
    logic [12:0] vec;
  } expT;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  expT  sbQ[$];
  expT  e;
  logic [12:0] obsVec;

  pg_port_controller_if #(.CNT_W(7)) pgIf ();

  pg_port_controller #(.CNT_W(7), .IDLE_THRESH(4), .WAKE_LAT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .pgIf  (pgIf)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign obsVec = {pgIf.pgState, pgIf.portReady, pgIf.pgSleep,
                   pgIf.wakeAck, pgIf.pgError, pgIf.utilCount};

  // Expected vector: ready/sleep follow from the state table of the port.
  function automatic expT mk(string name, logic [1:0] st, logic ack,
                             logic err, logic [6:0] util);
    expT r;
    r.name = name;
    r.vec  = {st, (st == S_ACTIVE), (st == S_SLEEP), ack, err, util};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(logic en, logic fv, logic be, logic wr);
    pgIf.pgEnable  = en;
    pgIf.flitValid = fv;
    pgIf.bufEmpty  = be;
    pgIf.wakeReq   = wr;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    applyStimulus(0, 0, 1, 0);
    #3;
    sbQ.push_back(mk("resetState", S_ACTIVE, 0, 0, 0));
    e = sbQ.pop_front(); checks++;
    if (obsVec !== e.vec) begin errors++; $display("[TB] FAIL %s: got %b want %b", e.name, obsVec, e.vec); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_gate_to_sleep();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 1, 0);
      sbQ.push_back(mk("countFlit", S_ACTIVE, 0, 0, 7'(i + 1)));
      tick();
      e = sbQ.pop_front(); checks++;
      if (obsVec !== e.vec) begin errors++; $display("[TB] FAIL %s: got %b want %b", e.name, obsVec, e.vec); end
    end
    applyStimulus(1, 0, 1, 0);
    sbQ.push_back(mk("enterDrain", S_DRAIN, 0, 0, 0));
    tick();
    e = sbQ.pop_front(); checks++;
    if (obsVec !== e.vec) begin errors++; $display("[TB] FAIL %s: got %b want %b", e.name, obsVec, e.vec); end
    applyStimulus(0, 0, 1, 0);
    sbQ.push_back(mk("enterSleep", S_SLEEP, 0, 0, 0));
    tick();
    e = sbQ.pop_front(); checks++;
    if (obsVec !== e.vec) begin errors++; $display("[TB] FAIL %s: got %b want %b", e.name, obsVec, e.vec); end
  endtask

  task automatic test_wake_timing();
    applyStimulus(0, 0, 1, 1);
    sbQ.push_back(mk("wakeEnter", S_WAKE, 0, 0, 0));
    tick();
    e = sbQ.pop_front(); checks++;
    if (obsVec !== e.vec) begin errors++; $display("[TB] FAIL %s: got %b want %b", e.name, obsVec, e.vec); end
    for (int i = 1; i < 8; i++) begin
      applyStimulus((i == 3), 0, 1, 1);
      sbQ.push_back(mk("wakeHold", S_WAKE, 0, 0, 0));
      tick();
      e = sbQ.pop_front(); checks++;
      if (obsVec !== e.vec) begin errors++; $display("[TB] FAIL %s cycle %0d: got %b want %b", e.name, i, obsVec, e.vec); end
    end
    applyStimulus(0, 0, 1, 0);
    sbQ.push_back(mk("wakeDoneAck", S_ACTIVE, 1, 0, 0));
    sbQ.push_back(mk("wakeAckDrop", S_ACTIVE, 0, 0, 0));
    for (int i = 0; i < 2; i++) begin
      tick();
      e = sbQ.pop_front(); checks++;
      if (obsVec !== e.vec) begin errors++; $display("[TB] FAIL %s: got %b want %b", e.name, obsVec, e.vec); end
    end
  endtask

  task automatic test_no_gate();
    // Four flits reach the threshold, so the epoch is not idle.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 1, 0);
      tick();
    end
    applyStimulus(1, 0, 1, 0);
    sbQ.push_back(mk("busyEpoch", S_ACTIVE, 0, 0, 0));
    tick();
    e = sbQ.pop_front(); checks++;
    if (obsVec !== e.vec) begin errors++; $display("[TB] FAIL %s: got %b want %b", e.name, obsVec, e.vec); end
    // Three flits plus one arriving with the epoch pulse.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 1, 0);
      tick();
    end
    applyStimulus(1, 1, 1, 0);
    sbQ.push_back(mk("lastFlitCounts", S_ACTIVE, 0, 0, 0));
    tick();
    e = sbQ.pop_front(); checks++;
    if (obsVec !== e.vec) begin errors++; $display("[TB] FAIL %s: got %b want %b", e.name, obsVec, e.vec); end
    // Idle epoch, but demand in the pulse cycle blocks gating.
    applyStimulus(1, 0, 1, 1);
    sbQ.push_back(mk("wakeReqBlocks", S_ACTIVE, 0, 0, 0));
    tick();
    e = sbQ.pop_front(); checks++;
    if (obsVec !== e.vec) begin errors++; $display("[TB] FAIL %s: got %b want %b", e.name, obsVec, e.vec); end
  endtask

  task automatic test_drain_abort();
    applyStimulus(1, 0, 0, 0);
    sbQ.push_back(mk("drainBusyBuf", S_DRAIN, 0, 0, 0));
    tick();
    e = sbQ.pop_front(); checks++;
    if (obsVec !== e.vec) begin errors++; $display("[TB] FAIL %s: got %b want %b", e.name, obsVec, e.vec); end
    for (int i = 0; i < 5; i++) begin
      applyStimulus((i == 2), 0, 0, 0);
      sbQ.push_back(mk("drainHold", S_DRAIN, 0, 0, 0));
      tick();
      e = sbQ.pop_front(); checks++;
      if (obsVec !== e.vec) begin errors++; $display("[TB] FAIL %s cycle %0d: got %b want %b", e.name, i, obsVec, e.vec); end
    end
    applyStimulus(0, 0, 0, 1);
    sbQ.push_back(mk("drainAbort", S_ACTIVE, 0, 0, 0));
    tick();
    e = sbQ.pop_front(); checks++;
    if (obsVec !== e.vec) begin errors++; $display("[TB] FAIL %s: got %b want %b", e.name, obsVec, e.vec); end
  endtask

  task automatic test_flit_in_sleep();
    applyStimulus(1, 0, 1, 0);
    tick();
    applyStimulus(0, 0, 1, 0);
    tick();
    applyStimulus(0, 1, 1, 0);
    sbQ.push_back(mk("strayFlit", S_WAKE, 0, 1, 1));
    tick();
    e = sbQ.pop_front(); checks++;
    if (obsVec !== e.vec) begin errors++; $display("[TB] FAIL %s: got %b want %b", e.name, obsVec, e.vec); end
    applyStimulus(0, 0, 1, 0);
    for (int i = 0; i < 7; i++) tick();
    sbQ.push_back(mk("errWakeDone", S_ACTIVE, 1, 1, 1));
    sbQ.push_back(mk("errSticky", S_ACTIVE, 0, 1, 1));
    for (int i = 0; i < 2; i++) begin
      tick();
      e = sbQ.pop_front(); checks++;
      if (obsVec !== e.vec) begin errors++; $display("[TB] FAIL %s: got %b want %b", e.name, obsVec, e.vec); end
    end
  endtask

  task automatic test_saturate();
    // Counter starts at 1 from the previous scenario.
    for (int i = 1; i <= 130; i++) begin
      applyStimulus(0, 1, 1, 0);
      if (i == 125 || i == 126 || i == 130)
        sbQ.push_back(mk("saturate", S_ACTIVE, 0, 1, (i + 1 > 127) ? 7'd127 : 7'(i + 1)));
      tick();
      if (i == 125 || i == 126 || i == 130) begin
        e = sbQ.pop_front(); checks++;
        if (obsVec !== e.vec) begin errors++; $display("[TB] FAIL %s at %0d: got %b want %b", e.name, i, obsVec, e.vec); end
      end
    end
    applyStimulus(1, 0, 1, 0);
    sbQ.push_back(mk("satNoGate", S_ACTIVE, 0, 1, 0));
    tick();
    e = sbQ.pop_front(); checks++;
    if (obsVec !== e.vec) begin errors++; $display("[TB] FAIL %s: got %b want %b", e.name, obsVec, e.vec); end
  endtask

  task automatic test_reset_mid();
    applyStimulus(1, 0, 1, 0);
    tick();
    applyStimulus(0, 0, 1, 0);
    sbQ.push_back(mk("preResetSleep", S_SLEEP, 0, 1, 0));
    tick();
    e = sbQ.pop_front(); checks++;
    if (obsVec !== e.vec) begin errors++; $display("[TB] FAIL %s: got %b want %b", e.name, obsVec, e.vec); end
    #2 reset = 1'b0;
    sbQ.push_back(mk("resetInSleep", S_ACTIVE, 0, 0, 0));
    #1;
    e = sbQ.pop_front(); checks++;
    if (obsVec !== e.vec) begin errors++; $display("[TB] FAIL %s: got %b want %b", e.name, obsVec, e.vec); end
    #1 reset = 1'b1;
    tick();
    applyStimulus(1, 0, 1, 0);
    tick();
    applyStimulus(0, 0, 1, 0);
    tick();
    applyStimulus(0, 0, 1, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 1, 0);
      tick();
    end
    sbQ.push_back(mk("preResetWake", S_WAKE, 0, 0, 3));
    e = sbQ.pop_front(); checks++;
    if (obsVec !== e.vec) begin errors++; $display("[TB] FAIL %s: got %b want %b", e.name, obsVec, e.vec); end
    #2 reset = 1'b0;
    sbQ.push_back(mk("resetInWake", S_ACTIVE, 0, 0, 0));
    #1;
    e = sbQ.pop_front(); checks++;
    if (obsVec !== e.vec) begin errors++; $display("[TB] FAIL %s: got %b want %b", e.name, obsVec, e.vec); end
    applyStimulus(0, 0, 1, 0);
    #1 reset = 1'b1;
    tick();
  endtask

  // Scenario sequence and final summary.
  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_gate_to_sleep();
    test_wake_timing();
    test_no_gate();
    test_drain_abort();
    test_flit_in_sleep();
    test_saturate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
